// File: rtl/iserdes_pkg.sv
// -----------------------------------------------------------------------------
// iserdes_pkg
// Shared definitions for the ISERDES word aligner:
//   - nibble / word geometry constants
//   - aligner FSM state encoding
//   - small helper for the wrapping nibble index
// No ports (package).
// -----------------------------------------------------------------------------
package iserdes_pkg;

  localparam int NIBBLE_W         = 4;
  localparam int WORD_W           = 16;
  localparam int NIBBLES_PER_WORD = WORD_W / NIBBLE_W;
  localparam int NIB_IDX_W        = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CHECK  = 3'd1,
    ST_SLIP   = 3'd2,
    ST_WAIT   = 3'd3,
    ST_LOCKED = 3'd4
  } state_e;

  // Index into the word being assembled; wraps 3 -> 0 by width.
  function automatic logic [NIB_IDX_W-1:0] nib_idx_inc(input logic [NIB_IDX_W-1:0] idx);
    return idx + 1'b1;
  endfunction

endpackage

// File: rtl/iserdes_nibble_packer.sv
// -----------------------------------------------------------------------------
// iserdes_nibble_packer
// Collects four consecutive nibbles into a 16-bit word. The first nibble lands
// in bits [3:0], the fourth in [15:12]. The word register and its valid pulse
// update on the clock after the fourth nibble is pushed.
// Ports:
//   clk           clock
//   resetb        asynchronous active-low reset
//   i_clear       drop any partial word and restart at nibble 0
//   i_push        accept i_nibble this cycle (ignored while i_clear is high)
//   i_nibble      nibble to store
//   o_word        last completed word (held between completions)
//   o_word_valid  one-cycle pulse when o_word updates
// -----------------------------------------------------------------------------
module iserdes_nibble_packer
  import iserdes_pkg::*;
(
  input  logic                clk,
  input  logic                resetb,
  input  logic                i_clear,
  input  logic                i_push,
  input  logic [NIBBLE_W-1:0] i_nibble,
  output logic [WORD_W-1:0]   o_word,
  output logic                o_word_valid
);

  logic [NIB_IDX_W-1:0] r_idx;
  logic [NIBBLE_W-1:0]  r_nib [NIBBLES_PER_WORD-1];
  logic [WORD_W-1:0]    r_word;
  logic                 r_word_valid;

  logic                 w_push;
  logic                 w_last;
  logic [WORD_W-1:0]    w_word_next;

  assign w_push = i_push && !i_clear;
  assign w_last = (r_idx == NIB_IDX_W'(NIBBLES_PER_WORD - 1));

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      r_idx <= '0;
    end else if (i_clear) begin
      r_idx <= '0;
    end else if (i_push) begin
      r_idx <= nib_idx_inc(r_idx);
    end
  end

  // Only the first three nibbles need storage; the fourth is taken straight
  // from the input when the word is committed.
  genvar gi;
  generate
    for (gi = 0; gi < NIBBLES_PER_WORD - 1; gi++) begin : g_nib
      always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
          r_nib[gi] <= '0;
        end else if (w_push && (r_idx == NIB_IDX_W'(gi))) begin
          r_nib[gi] <= i_nibble;
        end
      end
      assign w_word_next[gi*NIBBLE_W +: NIBBLE_W] = r_nib[gi];
    end
  endgenerate

  assign w_word_next[WORD_W-1 -: NIBBLE_W] = i_nibble;

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      r_word       <= '0;
      r_word_valid <= 1'b0;
    end else begin
      r_word_valid <= w_push && w_last;
      if (w_push && w_last) begin
        r_word <= w_word_next;
      end
    end
  end

  assign o_word       = r_word;
  assign o_word_valid = r_word_valid;

endmodule

// File: rtl/iserdes_word_aligner.sv
// -----------------------------------------------------------------------------
// iserdes_word_aligner
// Trains a 1:4 deserializer onto a known nibble pattern by pulsing BITSLIP
// until TRAIN_PATTERN is seen LOCK_COUNT times in a row, then assembles
// 16-bit words from the aligned nibble stream.
// Ports:
//   clk         CLKDIV-domain clock
//   resetb      asynchronous active-low reset
//   enable      level; low parks the aligner in IDLE
//   realign     one-cycle pulse; restarts training from any state
//   din         nibble from deserializer, din[0] oldest bit
//   din_valid   din qualifier; counters only advance when high
//   bitslip     one-cycle pulse to the deserializer BITSLIP input
//   locked      high while aligned
//   fail        sticky: a full cycle of 4 slips passed without lock
//   dout        assembled word, first nibble in [3:0]
//   dout_valid  one-cycle pulse when dout updates
//   slip_cnt    slips issued in the current training attempt, mod 4
// -----------------------------------------------------------------------------
module iserdes_word_aligner
  import iserdes_pkg::*;
#(
  parameter logic [NIBBLE_W-1:0] TRAIN_PATTERN = 4'hA,
  parameter int                  LOCK_COUNT    = 8,
  parameter int                  SLIP_WAIT     = 3
) (
  input  logic                clk,
  input  logic                resetb,
  input  logic                enable,
  input  logic                realign,
  input  logic [NIBBLE_W-1:0] din,
  input  logic                din_valid,
  output logic                bitslip,
  output logic                locked,
  output logic                fail,
  output logic [WORD_W-1:0]   dout,
  output logic                dout_valid,
  output logic [1:0]          slip_cnt
);

  localparam logic [7:0] MATCH_LAST = 8'(LOCK_COUNT - 1);
  localparam logic [3:0] WAIT_LAST  = 4'(SLIP_WAIT - 1);

  state_e     r_state;
  logic [7:0] r_match_cnt;
  logic [3:0] r_wait_cnt;
  logic [1:0] r_slip_cnt;
  logic       r_fail;
  logic       r_bitslip;
  logic       r_locked;

  state_e     w_state_next;
  logic [7:0] w_match_next;
  logic [3:0] w_wait_next;
  logic [1:0] w_slip_next;
  logic       w_fail_next;

  logic       w_pack_push;
  logic       w_pack_clear;

  always_comb begin
    w_state_next = r_state;
    w_match_next = r_match_cnt;
    w_wait_next  = r_wait_cnt;
    w_slip_next  = r_slip_cnt;
    w_fail_next  = r_fail;

    if (!enable) begin
      // slip_cnt and fail survive a disable; only realign/reset clear them.
      w_state_next = ST_IDLE;
      w_match_next = '0;
      w_wait_next  = '0;
    end else if (realign) begin
      w_state_next = ST_CHECK;
      w_match_next = '0;
      w_wait_next  = '0;
      w_slip_next  = '0;
      w_fail_next  = 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_state_next = ST_CHECK;
          w_match_next = '0;
          w_wait_next  = '0;
        end
        ST_CHECK: begin
          if (din_valid) begin
            if (din == TRAIN_PATTERN) begin
              if (r_match_cnt == MATCH_LAST) begin
                w_state_next = ST_LOCKED;
                w_match_next = '0;
              end else begin
                w_match_next = r_match_cnt + 8'd1;
              end
            end else begin
              w_state_next = ST_SLIP;
              w_match_next = '0;
              w_slip_next  = r_slip_cnt + 2'd1;
              // A fourth slip means every phase was tried once.
              if (r_slip_cnt == 2'd3) begin
                w_fail_next = 1'b1;
              end
            end
          end
        end
        ST_SLIP: begin
          // Lasts exactly one cycle regardless of din_valid.
          w_state_next = ST_WAIT;
          w_wait_next  = '0;
        end
        ST_WAIT: begin
          if (din_valid) begin
            if (r_wait_cnt == WAIT_LAST) begin
              w_state_next = ST_CHECK;
              w_wait_next  = '0;
              w_match_next = '0;
            end else begin
              w_wait_next = r_wait_cnt + 4'd1;
            end
          end
        end
        ST_LOCKED: begin
          w_state_next = ST_LOCKED;
        end
        default: begin
          w_state_next = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      r_state     <= ST_IDLE;
      r_match_cnt <= '0;
      r_wait_cnt  <= '0;
      r_slip_cnt  <= '0;
      r_fail      <= 1'b0;
      r_bitslip   <= 1'b0;
      r_locked    <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_match_cnt <= w_match_next;
      r_wait_cnt  <= w_wait_next;
      r_slip_cnt  <= w_slip_next;
      r_fail      <= w_fail_next;
      // Decoding the next state keeps these outputs registered yet aligned
      // with the state they describe.
      r_bitslip   <= (w_state_next == ST_SLIP);
      r_locked    <= (w_state_next == ST_LOCKED);
    end
  end

  // Realign or disable in the same cycle as the fourth nibble discards it.
  assign w_pack_push  = enable && !realign && din_valid && (r_state == ST_LOCKED);
  assign w_pack_clear = !enable || realign || (r_state != ST_LOCKED);

  iserdes_nibble_packer u_packer (
    .clk          (clk),
    .resetb       (resetb),
    .i_clear      (w_pack_clear),
    .i_push       (w_pack_push),
    .i_nibble     (din),
    .o_word       (dout),
    .o_word_valid (dout_valid)
  );

  assign bitslip  = r_bitslip;
  assign locked   = r_locked;
  assign fail     = r_fail;
  assign slip_cnt = r_slip_cnt;

endmodule

// File: tb/tb_iserdes_word_aligner.sv
// -----------------------------------------------------------------------------
// tb_iserdes_word_aligner
// Self-checking bench: a directed vector table, hand-written corner sequences
// and a randomized run checked against a behavioural reference model.
// Packed output order everywhere: {locked, bitslip, slip_cnt, fail,
// dout_valid, dout}.
// -----------------------------------------------------------------------------
module tb_iserdes_word_aligner;

  localparam logic [3:0] PAT   = 4'hA;
  localparam int         LOCKN = 8;
  localparam int         SWAIT = 3;

  logic        clk = 1'b0;
  logic        resetb;
  logic        enable;
  logic        realign;
  logic [3:0]  din;
  logic        din_valid;
  logic        bitslip;
  logic        locked;
  logic        fail;
  logic [15:0] dout;
  logic        dout_valid;
  logic [1:0]  slip_cnt;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  iserdes_word_aligner #(
    .TRAIN_PATTERN (PAT),
    .LOCK_COUNT    (LOCKN),
    .SLIP_WAIT     (SWAIT)
  ) dut (
    .clk        (clk),
    .resetb     (resetb),
    .enable     (enable),
    .realign    (realign),
    .din        (din),
    .din_valid  (din_valid),
    .bitslip    (bitslip),
    .locked     (locked),
    .fail       (fail),
    .dout       (dout),
    .dout_valid (dout_valid),
    .slip_cnt   (slip_cnt)
  );

  // ---------------------------------------------------------------- helpers
  function automatic logic [21:0] outs();
    return {locked, bitslip, slip_cnt, fail, dout_valid, dout};
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h, required %h", name, $time, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit en, input bit ra, input bit v, input logic [3:0] d);
    enable    = en;
    realign   = ra;
    din_valid = v;
    din       = d;
  endtask

  // ------------------------------------------------------ reference model
  // Training is viewed as: count consecutive matches; on a mismatch owe one
  // slip cycle, then skip SWAIT valid nibbles. Once locked, nibbles go into a
  // queue and every four of them form a word.
  bit         m_active, m_locked, m_pending, m_fail, m_dv;
  int         m_match, m_ignore, m_slips;
  logic [3:0] m_q[$];
  logic [15:0] m_dout;

  function automatic void m_reset();
    m_active = 0; m_locked = 0; m_pending = 0; m_fail = 0; m_dv = 0;
    m_match = 0; m_ignore = 0; m_slips = 0; m_dout = '0;
    m_q.delete();
  endfunction

  function automatic void m_step(input bit en, input bit ra, input bit v, input logic [3:0] d);
    m_dv = 0;
    if (!en) begin
      m_active = 0; m_locked = 0; m_pending = 0; m_ignore = 0; m_match = 0;
      m_q.delete();
    end else if (ra) begin
      m_active = 1; m_locked = 0; m_pending = 0; m_ignore = 0; m_match = 0;
      m_slips = 0; m_fail = 0;
      m_q.delete();
    end else if (!m_active) begin
      m_active = 1; m_match = 0;
    end else if (m_pending) begin
      m_pending = 0;
      m_ignore  = SWAIT;
    end else if (m_locked) begin
      if (v) begin
        m_q.push_back(d);
        if (m_q.size() == 4) begin
          m_dout = {m_q[3], m_q[2], m_q[1], m_q[0]};
          m_dv   = 1;
          m_q.delete();
        end
      end
    end else if (m_ignore > 0) begin
      if (v) m_ignore--;
    end else if (v) begin
      if (d == PAT) begin
        m_match++;
        if (m_match == LOCKN) begin
          m_locked = 1;
          m_match  = 0;
        end
      end else begin
        m_match   = 0;
        m_pending = 1;
        m_slips   = (m_slips + 1) % 4;
        if (m_slips == 0) m_fail = 1;
      end
    end
  endfunction

  function automatic logic [21:0] m_exp();
    logic [1:0] sc;
    sc = m_slips[1:0];
    return {m_locked, m_pending, sc, m_fail, m_dv, m_dout};
  endfunction

  task automatic do_reset();
    drive(0, 0, 0, 4'h0);
    resetb = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    cmp("reset_state", 32'(outs()), 32'h0);
    resetb = 1'b1;
    m_reset();
  endtask

  // ------------------------------------------------------ directed table
  typedef struct {
    bit          en;
    bit          ra;
    bit          v;
    logic [3:0]  d;
    bit          lk;
    bit          bs;
    logic [1:0]  sc;
    bit          f;
    bit          dv;
    logic [15:0] dout;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input bit en, input bit ra, input bit v, input logic [3:0] d,
                              input bit lk, input bit bs, input logic [1:0] sc, input bit f,
                              input bit dv, input logic [15:0] dw);
    vec_t t;
    t.en = en; t.ra = ra; t.v = v; t.d = d;
    t.lk = lk; t.bs = bs; t.sc = sc; t.f = f; t.dv = dv; t.dout = dw;
    tbl.push_back(t);
  endfunction

  // ------------------------------------------------------------ stimulus
  initial begin : main
    int         lock_edge;
    int         pulses;
    int         guard;
    bit         mostly_pat;
    bit         r_en, r_ra, r_v;
    logic [3:0] r_d;
    int         slip_edge[5];
    logic [1:0] slip_sc[5];

    resetb = 1'b1;
    drive(0, 0, 0, 4'h0);

    // Edge 1: IDLE->CHECK; edges 2..9: 8 matches -> locked after edge 9.
    add(1, 0, 1, 4'hA, 0, 0, 2'd0, 0, 0, 16'h0000);
    for (int k = 2; k <= 8; k++) add(1, 0, 1, 4'hA, 0, 0, 2'd0, 0, 0, 16'h0000);
    add(1, 0, 1, 4'hA, 1, 0, 2'd0, 0, 0, 16'h0000);
    add(1, 0, 1, 4'h1, 1, 0, 2'd0, 0, 0, 16'h0000);
    add(1, 0, 1, 4'h2, 1, 0, 2'd0, 0, 0, 16'h0000);
    add(1, 0, 1, 4'h3, 1, 0, 2'd0, 0, 0, 16'h0000);
    add(1, 0, 1, 4'h4, 1, 0, 2'd0, 0, 1, 16'h4321);
    // Second word with din_valid gaps in the middle.
    add(1, 0, 0, 4'hF, 1, 0, 2'd0, 0, 0, 16'h4321);
    add(1, 0, 1, 4'h5, 1, 0, 2'd0, 0, 0, 16'h4321);
    add(1, 0, 0, 4'h9, 1, 0, 2'd0, 0, 0, 16'h4321);
    add(1, 0, 1, 4'h6, 1, 0, 2'd0, 0, 0, 16'h4321);
    add(1, 0, 1, 4'h7, 1, 0, 2'd0, 0, 0, 16'h4321);
    add(1, 0, 1, 4'h8, 1, 0, 2'd0, 0, 1, 16'h8765);

    do_reset();
    foreach (tbl[i]) begin
      drive(tbl[i].en, tbl[i].ra, tbl[i].v, tbl[i].d);
      tick();
      $display("vec %0d: en=%0b ra=%0b v=%0b din=%h -> lk=%0b bs=%0b sc=%0d f=%0b dv=%0b dout=%h",
               i, tbl[i].en, tbl[i].ra, tbl[i].v, tbl[i].d,
               locked, bitslip, slip_cnt, fail, dout_valid, dout);
      cmp($sformatf("table[%0d]", i), 32'(outs()),
          32'({tbl[i].lk, tbl[i].bs, tbl[i].sc, tbl[i].f, tbl[i].dv, tbl[i].dout}));
    end

    // Two bad nibbles then pattern: one slip, 3 ignored, lock after edge 14.
    do_reset();
    lock_edge = 0;
    pulses    = 0;
    for (int e = 1; e <= 24; e++) begin
      drive(1, 0, 1, (e == 2 || e == 3) ? 4'h5 : 4'hA);
      tick();
      if (bitslip) pulses++;
      if (locked && lock_edge == 0) lock_edge = e;
    end
    $display("one_slip: pulses=%0d lock_edge=%0d slip_cnt=%0d", pulses, lock_edge, slip_cnt);
    cmp("one_slip_pulses", 32'(pulses), 32'd1);
    cmp("one_slip_lock_edge", 32'(lock_edge), 32'd14);
    cmp("one_slip_slip_cnt", 32'(slip_cnt), 32'd1);

    // Constant bad nibble: slips every 5 valid cycles, fail after the 4th,
    // slipping continues afterwards.
    do_reset();
    slip_edge = '{2, 7, 12, 17, 22};
    slip_sc   = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    for (int e = 1; e <= 23; e++) begin
      bit exp_bs;
      drive(1, 0, 1, 4'h3);
      tick();
      exp_bs = 0;
      for (int s = 0; s < 5; s++) begin
        if (slip_edge[s] == e) begin
          exp_bs = 1;
          cmp($sformatf("slip_cnt_after_slip%0d", s + 1), 32'(slip_cnt), 32'(slip_sc[s]));
        end
      end
      $display("const3 edge %0d: bs=%0b sc=%0d fail=%0b", e, bitslip, slip_cnt, fail);
      cmp($sformatf("const3_bitslip_e%0d", e), 32'(bitslip), 32'(exp_bs));
      cmp($sformatf("const3_fail_e%0d", e), 32'(fail), (e >= 17) ? 32'd1 : 32'd0);
    end

    // Realign mid-word: partial word dropped, relock assembles cleanly.
    do_reset();
    guard = 0;
    drive(1, 0, 1, PAT);
    do begin tick(); guard++; end while (!locked && guard < 30);
    cmp("realign_first_lock", 32'(locked), 32'd1);
    drive(1, 0, 1, 4'h7); tick();
    drive(1, 0, 1, 4'h9); tick();
    drive(1, 1, 1, 4'hB); tick();
    $display("realign: lk=%0b fail=%0b dv=%0b", locked, fail, dout_valid);
    cmp("realign_locked", 32'(locked), 32'd0);
    cmp("realign_fail", 32'(fail), 32'd0);
    cmp("realign_dv", 32'(dout_valid), 32'd0);
    drive(1, 0, 0, 4'hB);
    for (int k = 0; k < 3; k++) begin
      tick();
      cmp("realign_no_dv", 32'(dout_valid), 32'd0);
    end
    guard = 0;
    drive(1, 0, 1, PAT);
    do begin tick(); guard++; end while (!locked && guard < 30);
    cmp("realign_relock", 32'(locked), 32'd1);
    for (int k = 1; k <= 4; k++) begin
      drive(1, 0, 1, 4'(k));
      tick();
    end
    $display("relock word: dv=%0b dout=%h", dout_valid, dout);
    cmp("relock_word", 32'({dout_valid, dout}), 32'h1_4321);

    // Drive into fail, then assert reset between edges: outputs clear at once.
    drive(1, 1, 1, 4'h3); tick();
    drive(1, 0, 1, 4'h3);
    guard = 0;
    do begin tick(); guard++; end while (!fail && guard < 40);
    cmp("pre_async_fail", 32'(fail), 32'd1);
    #3;
    resetb = 1'b0;
    #1;
    $display("async reset: outs=%h", outs());
    cmp("async_reset_outs", 32'(outs()), 32'h0);
    #2;

    // Randomized run against the model.
    do_reset();
    mostly_pat = 1;
    for (int i = 0; i < 2000; i++) begin
      if ((i % 64) == 0) mostly_pat = ($urandom_range(0, 2) != 0);
      r_en = ($urandom_range(0, 99) < 98);
      r_ra = ($urandom_range(0, 99) < 2);
      r_v  = ($urandom_range(0, 99) < 85);
      if (mostly_pat && $urandom_range(0, 19) != 0) r_d = PAT;
      else r_d = 4'($urandom_range(0, 15));
      drive(r_en, r_ra, r_v, r_d);
      m_step(r_en, r_ra, r_v, r_d);
      tick();
      $display("rand %0d: en=%0b ra=%0b v=%0b din=%h -> outs=%h model=%h",
               i, r_en, r_ra, r_v, r_d, outs(), m_exp());
      cmp($sformatf("rand[%0d]", i), 32'(outs()), 32'(m_exp()));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/iserdes_word_aligner.md
ISERDES_WORD_ALIGNER -- requirements
Module: iserdes_word_aligner

Interface
REQ-001 SHALL have parameter TRAIN_PATTERN, 4'hA, nibble expected during training.
REQ-002 SHALL have parameter LOCK_COUNT, 8, number of consecutive matching nibbles needed to declare lock (range 1..255).
REQ-003 SHALL have parameter SLIP_WAIT, 3, number of valid nibbles ignored after each bitslip pulse (range 1..15).
REQ-004 clk  input  1  single clock; same as the deserializer CLKDIV domain.
REQ-005 resetb  input  1  reset, asynchronous, active-low.
REQ-006 enable  input  1  level; low forces IDLE.
REQ-007 realign  input  1  one-cycle pulse; restarts training from any state.
REQ-008 din  input  4  parallel nibble from deserializer; din[0]=Q1=oldest bit, din[3]=Q4=newest.
REQ-009 din_valid  input  1  din qualifier; all counters advance only on din_valid=1.
REQ-010 bitslip  output  1  one-cycle pulse to deserializer BITSLIP.
REQ-011 locked  output  1  high while in LOCKED.
REQ-012 fail  output  1  sticky; set after 4 slips without lock; cleared by realign or reset.
REQ-013 dout  output  16  assembled word; first nibble after lock in dout[3:0], fourth in dout[15:12].
REQ-014 dout_valid  output  1  one-cycle pulse when dout updates.
REQ-015 slip_cnt  output  2  slips issued in current training attempt (mod 4).

Function
REQ-016 FSM states SHALL be IDLE, CHECK, SLIP, WAIT, LOCKED.
REQ-017 IDLE -> CHECK on enable=1; any state -> IDLE on enable=0 (priority over all else).
REQ-018 CHECK, din_valid and din==TRAIN_PATTERN: match counter +1; counter reaching LOCK_COUNT -> LOCKED next cycle.
REQ-019 CHECK, din_valid and din!=TRAIN_PATTERN: match counter cleared, -> SLIP.
REQ-020 SLIP: bitslip=1 for exactly one cycle, slip_cnt +1 (wraps 3->0), -> WAIT; a wrap 3->0 sets fail.
REQ-021 WAIT: count SLIP_WAIT valid nibbles, then -> CHECK with match counter 0.
REQ-022 fail SHALL NOT stop training; slipping continues cyclically.
REQ-023 LOCKED: nibble index 0..3 advances per din_valid; at index 3 dout loads {din, n2, n1, n0} and dout_valid pulses the next cycle; index wraps to 0.
REQ-024 LOCKED: data content not checked; lock held until realign or enable=0.
REQ-025 realign pulse (enable=1): -> CHECK next cycle, clears match counter, nibble index, slip_cnt, fail; partial word discarded, no dout_valid.
REQ-026 realign and enable=0 same cycle: enable wins (IDLE).
REQ-027 din_valid=0 SHALL freeze all counters and hold state except SLIP (always one cycle).
REQ-028 bitslip SHALL never be high in two consecutive cycles.
REQ-029 Latency: fourth valid nibble of a word -> dout_valid exactly 1 cycle later.

Reset
REQ-030 resetb=0 SHALL asynchronously force IDLE; bitslip, locked, fail, dout_valid = 0; dout = 16'h0000; slip_cnt = 0; all internal counters 0.
REQ-031 Release of resetb SHALL take effect on the next rising clk; first possible state is CHECK one cycle after release if enable=1.
REQ-032 Reset mid-word SHALL discard partial nibbles with no dout_valid.

Structure
REQ-033 State encoding and nibble/word width constants SHALL live in shared package iserdes_pkg.
REQ-034 Single module; optional sub-module iserdes_nibble_packer (nibble index + 16-bit assembly register) is natural.
REQ-035 All outputs SHALL be registered.

Verification
REQ-036 Reset, enable=1, din=4'hA valid every cycle -> locked=1 after 8 valid nibbles + 1 cycle, bitslip never pulses, slip_cnt=0.
REQ-037 din=4'h5 for 2 valid nibbles then 4'hA -> one bitslip pulse, 3 ignored nibbles, then lock after 8 matches; slip_cnt=1.
REQ-038 din constant 4'h3 -> bitslip every 5 valid cycles (1 slip+3 wait+1 check), fail=1 after 4th slip, slip_cnt=0.
REQ-039 Locked, nibbles 1,2,3,4 -> dout=16'h4321, dout_valid one cycle after nibble 4; din_valid gaps delay but do not corrupt.
REQ-040 Locked, 2 nibbles in, realign -> locked=0, no dout_valid, fail=0; resetb=0 asynchronous mid-training -> all outputs 0 immediately.
